wb_led_sched: RTL and testbench

//  Wishbone-programmable blink scheduler. Drives NUM_LED LED outputs, each channel
//  off, on, free-running blink or N-pulse burst, timed from one shared prescaler.

---
 rtl/wb_led_sched_pkg.sv | 46 ++++
 rtl/wb_led_sched_if.sv | 21 ++
 rtl/wb_led_sched_chan.sv | 89 ++++++++
 rtl/wb_led_sched.sv | 143 ++++++++++++++
 tb/tb_wb_led_sched.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/wb_led_sched_pkg.sv
// Shared definitions for the Wishbone LED blink scheduler: register map,
// channel mode encodings, register field positions and a byte-lane helper.
package wb_led_sched_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_BURST = 2'b11
  } mode_e;

  // Word indices (byte address bits [7:2]).
  localparam logic [5:0] REG_CTRL      = 6'h00;
  localparam logic [5:0] REG_PRESC     = 6'h01;
  localparam logic [5:0] REG_STATUS    = 6'h02;
  localparam logic [5:0] REG_DONECLR   = 6'h03;
  localparam logic [5:0] REG_CHAN_BASE = 6'h04;

  localparam int CTRL_GEN_BIT    = 0;
  localparam int CTRL_SYNC_BIT   = 1;
  localparam int CFG_BURST_LSB   = 8;
  localparam int STATUS_DONE_LSB = 8;

  typedef struct packed {
    logic [7:0] burst;
    mode_e      mode;
  } cfg_t;

  function automatic logic [15:0] merge16(input logic [15:0] old_v,
                                          input logic [15:0] new_v,
                                          input logic [1:0]  sel);
    merge16 = old_v;
    if (sel[0]) merge16[7:0]  = new_v[7:0];
    if (sel[1]) merge16[15:8] = new_v[15:8];
  endfunction

  function automatic logic [15:0] cfg_to_word(input cfg_t c);
    cfg_to_word = {c.burst, 6'b0, c.mode};
  endfunction

  function automatic cfg_t word_to_cfg(input logic [15:0] w);
    word_to_cfg.burst = w[CFG_BURST_LSB +: 8];
    word_to_cfg.mode  = mode_e'(w[1:0]);
  endfunction

endpackage

// File: rtl/wb_led_sched_if.sv
// Wishbone classic slave bus bundle for the LED scheduler.
interface wb_led_sched_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_ack_o, wb_dat_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/wb_led_sched_chan.sv
// One LED channel: half-period counter, burst remaining-toggle counter and
// the off/on/blink/burst state machine. A restart always beats a tick.
module wb_led_chan
  import wb_led_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        restart,
  input  mode_e       mode,
  input  logic [7:0]  burst,
  input  logic [15:0] half,
  output logic        led,
  output logic        done_pulse
);

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_BLINK, ST_BURST} state_e;

  state_e      state_q, state_d;
  logic        led_q, led_d;
  logic [15:0] ccnt_q, ccnt_d;
  logic [8:0]  rem_q, rem_d;
  logic [15:0] lim;

  // A zero half-period behaves as one tick; >= lets a shrunk HALF toggle on the next tick.
  assign lim = (half == 16'd0) ? 16'd0 : half - 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      led_q   <= 1'b0;
      ccnt_q  <= 16'd0;
      rem_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      ccnt_q  <= ccnt_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    led_d      = led_q;
    ccnt_d     = ccnt_q;
    rem_d      = rem_q;
    done_pulse = 1'b0;
    if (restart) begin
      ccnt_d = 16'd0;
      rem_d  = 9'd0;
      unique case (mode)
        MODE_OFF:   begin state_d = ST_OFF;   led_d = 1'b0; end
        MODE_ON:    begin state_d = ST_ON;    led_d = 1'b1; end
        MODE_BLINK: begin state_d = ST_BLINK; led_d = 1'b1; end
        MODE_BURST: begin
          if (burst == 8'd0) begin
            state_d    = ST_OFF;
            led_d      = 1'b0;
            done_pulse = 1'b1;
          end else begin
            state_d = ST_BURST;
            led_d   = 1'b1;
            rem_d   = {burst, 1'b0} - 9'd1;
          end
        end
        default: begin state_d = ST_OFF; led_d = 1'b0; end
      endcase
    end else if (tick && (state_q == ST_BLINK || state_q == ST_BURST)) begin
      if (ccnt_q >= lim) begin
        ccnt_d = 16'd0;
        if (state_q == ST_BLINK) begin
          led_d = ~led_q;
        end else if (rem_q == 9'd0) begin
          led_d      = 1'b0;
          state_d    = ST_OFF;
          done_pulse = 1'b1;
        end else begin
          led_d = ~led_q;
          rem_d = rem_q - 9'd1;
        end
      end else begin
        ccnt_d = ccnt_q + 16'd1;
      end
    end
  end

  assign led = led_q;

endmodule

// File: rtl/wb_led_sched.sv
// Wishbone-programmable LED blink scheduler: bus decode, CTRL/PRESCALE,
// shared prescaler, STATUS/DONE bookkeeping and NUM_LED channel instances.
module wb_led_sched
  import wb_led_sched_pkg::*;
#(
  parameter int          NUM_LED   = 4,
  parameter logic [15:0] PRESC_RST = 16'd999
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_led_sched_if.slave      wb,
  output logic [NUM_LED-1:0] led_o
);

  logic                           ack_r;
  logic                           access;
  logic                           wr;
  logic [5:0]                     idx;
  logic                           gen_q;
  logic [15:0]                    presc_q;
  logic [15:0]                    pcnt_q;
  logic                           tick;
  logic                           sync;
  logic                           done_clr_wr;
  logic [NUM_LED-1:0]             done_q;
  logic [NUM_LED-1:0]             done_pulse;
  logic [NUM_LED-1:0][15:0]       cfg_rd;
  logic [NUM_LED-1:0][15:0]       half_rd;
  logic [31:0]                    rdata;
  logic [31:0]                    dat_o_q;
  logic                           unused_bits;

  assign unused_bits = ^{wb.wb_adr_i[31:8], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:16], wb.wb_sel_i[3:2]};

  assign idx         = wb.wb_adr_i[7:2];
  assign access      = wb.wb_stb_i & wb.wb_cyc_i & ~ack_r;
  assign wr          = access & wb.wb_we_i;
  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & ack_r;
  assign wb.wb_dat_o = dat_o_q;

  assign sync        = wr && (idx == REG_CTRL) && wb.wb_sel_i[0]
                       && wb.wb_dat_i[CTRL_SYNC_BIT];
  assign done_clr_wr = wr && (idx == REG_DONECLR) && wb.wb_sel_i[0];
  assign tick        = gen_q && (pcnt_q >= presc_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      dat_o_q <= 32'd0;
      gen_q   <= 1'b0;
      presc_q <= PRESC_RST;
    end else begin
      ack_r <= access;
      if (access && !wb.wb_we_i) dat_o_q <= rdata;
      if (wr && idx == REG_CTRL && wb.wb_sel_i[0]) gen_q <= wb.wb_dat_i[CTRL_GEN_BIT];
      if (wr && idx == REG_PRESC)
        presc_q <= merge16(presc_q, wb.wb_dat_i[15:0], wb.wb_sel_i[1:0]);
    end
  end

  // Shared prescaler: wraps after the tick cycle, freezes while GEN is clear.
  always_ff @(posedge clk) begin
    if (!rst_n)     pcnt_q <= 16'd0;
    else if (gen_q) pcnt_q <= tick ? 16'd0 : pcnt_q + 16'd1;
  end

  // A completion pulse wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      for (int i = 0; i < NUM_LED; i++) begin
        if (done_pulse[i])                        done_q[i] <= 1'b1;
        else if (done_clr_wr && wb.wb_dat_i[i])   done_q[i] <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_LED; g++) begin : g_chan
    localparam logic [5:0] CFG_IDX  = REG_CHAN_BASE + 6'(2 * g);
    localparam logic [5:0] HALF_IDX = REG_CHAN_BASE + 6'(2 * g + 1);

    cfg_t        cfg_q;
    cfg_t        cfg_new;
    cfg_t        cfg_ch;
    logic [15:0] half_q;
    logic        cfg_wr;
    logic        half_wr;

    assign cfg_wr  = wr && (idx == CFG_IDX);
    assign half_wr = wr && (idx == HALF_IDX);
    assign cfg_new = word_to_cfg(merge16(cfg_to_word(cfg_q), wb.wb_dat_i[15:0],
                                         wb.wb_sel_i[1:0]));
    // The channel must see the value being written on its restart edge.
    assign cfg_ch  = cfg_wr ? cfg_new : cfg_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cfg_q  <= '{burst: 8'd0, mode: MODE_OFF};
        half_q <= 16'd0;
      end else begin
        if (done_pulse[g])  cfg_q <= '{burst: cfg_ch.burst, mode: MODE_OFF};
        else if (cfg_wr)    cfg_q <= cfg_new;
        if (half_wr) half_q <= merge16(half_q, wb.wb_dat_i[15:0], wb.wb_sel_i[1:0]);
      end
    end

    assign cfg_rd[g]  = cfg_to_word(cfg_q);
    assign half_rd[g] = half_q;

    wb_led_chan u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick       (tick),
      .restart    (cfg_wr | sync),
      .mode       (cfg_ch.mode),
      .burst      (cfg_ch.burst),
      .half       (half_q),
      .led        (led_o[g]),
      .done_pulse (done_pulse[g])
    );
  end

  always_comb begin
    rdata = 32'd0;
    case (idx)
      REG_CTRL:   rdata[CTRL_GEN_BIT] = gen_q;
      REG_PRESC:  rdata[15:0] = presc_q;
      REG_STATUS: begin
        rdata[NUM_LED-1:0]                 = led_o;
        rdata[STATUS_DONE_LSB +: NUM_LED]  = done_q;
      end
      default: begin
        for (int i = 0; i < NUM_LED; i++) begin
          if (idx == REG_CHAN_BASE + 6'(2 * i))     rdata[15:0] = cfg_rd[i];
          if (idx == REG_CHAN_BASE + 6'(2 * i + 1)) rdata[15:0] = half_rd[i];
        end
      end
    endcase
  end

endmodule

// File: tb/tb_wb_led_sched.sv
// Directed bench for wb_led_sched: bus access timing, blink/burst timing,
// DONE handling, GEN freeze, SYNC, byte lanes and reset mid-operation.
module tb_wb_led_sched;

  logic       clk;
  logic       rst_n;
  logic [3:0] led_o;
  logic [31:0] rdata;
  int total;
  int bad;

  wb_led_sched_if wb_bus ();

  wb_led_sched #(.NUM_LED(4), .PRESC_RST(16'd999)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb_bus),
    .led_o (led_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    wb_bus.wb_stb_i = 1'b0;
    wb_bus.wb_cyc_i = 1'b0;
    wb_bus.wb_we_i  = 1'b0;
    wb_bus.wb_adr_i = 32'd0;
    wb_bus.wb_sel_i = 4'd0;
    wb_bus.wb_dat_i = 32'd0;
  endtask

  // Returns on the falling edge right after the acknowledging rising edge.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel);
    int n;
    @(negedge clk);
    wb_bus.wb_stb_i = 1'b1;
    wb_bus.wb_cyc_i = 1'b1;
    wb_bus.wb_we_i  = we;
    wb_bus.wb_adr_i = adr;
    wb_bus.wb_sel_i = sel;
    wb_bus.wb_dat_i = dat;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (wb_bus.wb_ack_o !== 1'b1 && n < 8);
    chk("ack", {31'd0, wb_bus.wb_ack_o}, 32'd1);
    rdata = wb_bus.wb_dat_o;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    bus(1'b1, adr, dat, 4'hF);
  endtask

  task automatic rd(input logic [31:0] adr);
    bus(1'b0, adr, 32'd0, 4'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_led", {28'd0, led_o}, 32'd0);
    chk("rst_dat", wb_bus.wb_dat_o, 32'd0);
    chk("rst_ack", {31'd0, wb_bus.wb_ack_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    rd(32'h04); chk("presc_rst", rdata, 32'h3E7);
    rd(32'h08); chk("status_rst", rdata, 32'h0);
    rd(32'h00); chk("ctrl_rst", rdata, 32'h0);

    // Held strobe: ack every second clock, one clock wide.
    @(negedge clk);
    wb_bus.wb_stb_i = 1'b1; wb_bus.wb_cyc_i = 1'b1; wb_bus.wb_adr_i = 32'h04;
    @(posedge clk); #1; chk("ack_b2b_1", {31'd0, wb_bus.wb_ack_o}, 32'd1);
    @(posedge clk); #1; chk("ack_b2b_2", {31'd0, wb_bus.wb_ack_o}, 32'd0);
    @(posedge clk); #1; chk("ack_b2b_3", {31'd0, wb_bus.wb_ack_o}, 32'd1);
    @(negedge clk); bus_idle();
    #1; chk("ack_drop", {31'd0, wb_bus.wb_ack_o}, 32'd0);

    // Blink on channel 0 with a tick every clock and half-period 3.
    wr(32'h04, 32'h0);
    wr(32'h14, 32'h3);
    wr(32'h00, 32'h1);
    wr(32'h10, 32'h2);
    chk("blink_start", {28'd0, led_o}, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      chk($sformatf("blink_k%0d", k), {31'd0, led_o[0]}, ((k / 3) % 2 == 0) ? 32'd1 : 32'd0);
    end

    // Burst of two pulses on channel 1, half-period 1.
    wr(32'h1C, 32'h1);
    wr(32'h18, 32'h0203);
    chk("burst_start", {31'd0, led_o[1]}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("burst_k%0d", k), {31'd0, led_o[1]}, (k == 2) ? 32'd1 : 32'd0);
    end
    rd(32'h08);
    chk("burst_done", {24'd0, rdata[15:8]}, 32'h02);
    chk("burst_leds", {29'd0, rdata[3:1]}, 32'h0);
    rd(32'h18); chk("burst_cfg_off", rdata, 32'h0200);
    wr(32'h0C, 32'h02);
    rd(32'h08); chk("doneclr", {24'd0, rdata[15:8]}, 32'h00);

    // Burst with zero count completes on the write edge.
    wr(32'h20, 32'h01);
    chk("ch2_on", {31'd0, led_o[2]}, 32'd1);
    wr(32'h20, 32'h03);
    chk("burst0_led", {31'd0, led_o[2]}, 32'd0);
    rd(32'h08); chk("burst0_done", {24'd0, rdata[15:8]}, 32'h04);
    rd(32'h20); chk("burst0_cfg", rdata, 32'h0);
    wr(32'h0C, 32'h04);

    // Two blink channels, SYNC, then a 20-clock GEN freeze.
    wr(32'h2C, 32'h3);
    wr(32'h28, 32'h2);
    wr(32'h00, 32'h3);
    chk("sync1", {28'd0, led_o}, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sync_k%0d", k), {28'd0, led_o}, (k < 3) ? 32'h9 : 32'h0);
    end
    wr(32'h00, 32'h0);
    chk("freeze_edge", {28'd0, led_o}, 32'h9);
    repeat (20) @(posedge clk);
    #1; chk("frozen", {28'd0, led_o}, 32'h9);
    wr(32'h00, 32'h1);
    chk("resume0", {28'd0, led_o}, 32'h9);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("resume_k%0d", k), {28'd0, led_o}, (k < 3) ? 32'h9 : 32'h0);
    end
    wr(32'h00, 32'h3);
    chk("sync2", {28'd0, led_o}, 32'h9);
    @(posedge clk); #1; chk("sync2_hold", {28'd0, led_o}, 32'h9);

    // Byte lanes and unmapped space.
    bus(1'b1, 32'h14, 32'h0000FFFF, 4'b0001);
    rd(32'h14); chk("sel_half0", rdata, 32'h00FF);
    rd(32'h7C); chk("unmapped_rd", rdata, 32'h0);
    wr(32'h7C, 32'hFFFF_FFFF);
    rd(32'h04); chk("unmapped_wr", rdata, 32'h0);

    // Reset in the middle of a burst and of a bus cycle.
    wr(32'h1C, 32'h10);
    wr(32'h18, 32'h0303);
    chk("burst2_start", {31'd0, led_o[1]}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    wb_bus.wb_stb_i = 1'b1; wb_bus.wb_cyc_i = 1'b1; wb_bus.wb_adr_i = 32'h04;
    @(posedge clk); #1;
    chk("rst_mid_led", {28'd0, led_o}, 32'h0);
    chk("rst_mid_ack", {31'd0, wb_bus.wb_ack_o}, 32'd0);
    @(negedge clk); bus_idle();
    @(negedge clk); rst_n = 1'b1;
    rd(32'h04); chk("rst2_presc", rdata, 32'h3E7);
    rd(32'h08); chk("rst2_status", rdata, 32'h0);
    rd(32'h18); chk("rst2_cfg1", rdata, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
